// File: rtl/shader_pkg.sv
// +----------------------------------------------------------------------------+
// | shader_pkg : shared raster-pipeline types and default dimensions           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package shader_pkg;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;

    // Coordinate widths shared with draw_line
    localparam int XW_DEF = 11;
    localparam int YW_DEF = 10;
    localparam int ZW_DEF = 11;
    localparam int CW_DEF = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } span_state_t;

endpackage

`default_nettype wire

// File: rtl/span_fill.sv
// +----------------------------------------------------------------------------+
// | span_fill : scanline span rasteriser, one pixel write per x over valid/ready |
// | Optional x clipping to H_RES-1 with macro SPAN_CLIP_EN.   Rev 1.0          |
// +----------------------------------------------------------------------------+
`default_nettype none

module span_fill
    import shader_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int XW    = XW_DEF,
    parameter int YW    = YW_DEF,
    parameter int ZW    = ZW_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          draw,
    input  logic [XW-1:0] start_x,
    input  logic [XW-1:0] end_x,
    input  logic [ZW-1:0] z_coord,
    input  logic [YW-1:0] y_coord,
    input  logic [CW-1:0] color,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [ZW-1:0] pix_z,
    output logic [CW-1:0] pix_color,
    output logic          pix_last,
    output logic          busy,
    output logic          span_done
);

    span_state_t   state_q, state_d;
    logic [XW-1:0] cur_x_q, cur_x_d;
    logic [XW-1:0] x_hi_q, x_hi_d;
    logic [YW-1:0] y_q, y_d;
    logic [ZW-1:0] z_q, z_d;
    logic [CW-1:0] color_q, color_d;
    logic          span_done_q, span_done_d;

    logic [XW-1:0] w_x_lo;
    logic [XW-1:0] w_x_hi;
    logic [XW-1:0] w_x_hi_eff;
    logic          w_empty;
    logic          w_accept;

    // Upstream normally sorts the endpoints, but ordering is re-established here
    assign w_x_lo = (start_x <= end_x) ? start_x : end_x;
    assign w_x_hi = (start_x <= end_x) ? end_x   : start_x;

`ifdef SPAN_CLIP_EN
    localparam logic [XW-1:0] X_MAX = XW'(H_RES - 1);
    assign w_x_hi_eff = (w_x_hi > X_MAX) ? X_MAX : w_x_hi;
    assign w_empty    = (w_x_lo > X_MAX);
`else
    assign w_x_hi_eff = w_x_hi;
    assign w_empty    = 1'b0;
`endif

    assign w_accept = (state_q == FILL) && pix_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_x_q     <= '0;
            x_hi_q      <= '0;
            y_q         <= '0;
            z_q         <= '0;
            color_q     <= '0;
            span_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_x_q     <= cur_x_d;
            x_hi_q      <= x_hi_d;
            y_q         <= y_d;
            z_q         <= z_d;
            color_q     <= color_d;
            span_done_q <= span_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_x_d     = cur_x_q;
        x_hi_d      = x_hi_q;
        y_d         = y_q;
        z_d         = z_q;
        color_d     = color_q;
        span_done_d = span_done_q;

        unique case (state_q)
            IDLE: begin
                if (draw) begin
                    y_d     = y_coord;
                    z_d     = z_coord;
                    color_d = color;
                    if (w_empty) begin
                        // Fully clipped span completes without entering FILL
                        span_done_d = 1'b1;
                    end else begin
                        cur_x_d     = w_x_lo;
                        x_hi_d      = w_x_hi_eff;
                        span_done_d = 1'b0;
                        state_d     = FILL;
                    end
                end
            end
            FILL: begin
                if (w_accept) begin
                    if (cur_x_q == x_hi_q) begin
                        span_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        cur_x_d = cur_x_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pix_valid = (state_q == FILL);
    assign busy      = (state_q == FILL);
    assign pix_last  = (state_q == FILL) && (cur_x_q == x_hi_q);
    assign pix_x     = cur_x_q;
    assign pix_y     = y_q;
    assign pix_z     = z_q;
    assign pix_color = color_q;
    assign span_done = span_done_q;

endmodule

`default_nettype wire
